display_scan_ctrl: RTL and testbench
====================================

# display_scan_ctrl

Front-end controller for the two-digit 7-segment display. It captures a 7-bit binary value and converts it to two BCD digits with a sequential shift-add-3 (double-dabble) engine. It then time-multiplexes the units and tens digits onto a single 4-bit digit bus that feeds the combinational segment decoder, and drives the matching one-hot anode enables.

## Interface
- REFRESH_DIV, default 50000: clock cycles each digit stays active; legal range ≥ 2.
- LZ_BLANK, default 1: when 1, a zero tens digit is blanked.

- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- value_in  in  7  binary value to display; sampled only on an accepted load.
- load  in  1  single-cycle strobe; accepted only when busy=0.
- busy  out  1  high while a conversion is in progress.
- ovf  out  1  high when the last accepted value was greater than 99.
- digit_out  out  4  BCD digit for the currently active slot, routed to the segment decoder.
- anode_en  out  2  active-high, one-hot digit enable: bit0 selects units, bit1 selects tens; 2'b00 means the slot is blanked.

## Operation
- **Reset values (asynchronous, all outputs):** busy=0, ovf=0, digit_out=0, anode_en=2'b01. Internal state: tens=0, units=0, sel=0 (units slot), refresh counter=0, FSM=IDLE.
- **Conversion FSM states:** IDLE and CONV.
- **IDLE:**
  - On load=1, capture v = min(value_in, 99).
  - Set ovf = (value_in > 99).
  - Clear the 8-bit BCD shift register; set step count = 0; go to CONV.
- **CONV:** each cycle performs one double-dabble step:
  - For each BCD nibble ≥ 5, add 3 to that nibble.
  - Shift {BCD, binary} left by 1; the binary MSB enters BCD bit 0.
  - After step 7, write BCD[7:4] to tens and BCD[3:0] to units, then return to IDLE.
- **Display registers:** tens and units change only when step 7 completes. They are never partially updated, so the display does not tear mid-conversion.
- **Load while busy:** load=1 with busy=1 is ignored. value_in and ovf are not resampled.
- **Scan counter:**
  - Counts 0 to REFRESH_DIV-1 continuously. At the wrap, sel toggles.
  - The counter runs independently of load and conversion.
- **Output decode** (combinational from registers only, no input-to-output path):
  - digit_out = sel ? tens : units.
  - anode_en = sel ? 2'b10 : 2'b01.
  - Override: if LZ_BLANK=1, sel=1 and tens=0, then anode_en=2'b00. digit_out still equals tens (0).
- **Units digit:** never blanked; a value of 0 displays as "0".
- **ovf:** holds until the next accepted load.
- **Arithmetic:** BCD nibbles are 4 bits; add-3 never carries across nibbles. Saturation to 99 happens before conversion. Counter width is clog2(REFRESH_DIV).

## Timing
- **Load to display:** load is sampled at edge E0.
  - busy=1 and ovf updated after E0.
  - Steps execute at edges E1..E7.
  - tens/units update and busy=0 after E7.
  - busy is high for exactly 7 cycles.
- **Back-to-back loads:** the earliest next accepted load is the one sampled at E8.
- **Reset during CONV:** aborts the conversion; the pending result is discarded. After release, the FSM is in IDLE with the reset values above.
- **Reset release:** the first units slot lasts REFRESH_DIV cycles from the first active edge. The slot then toggles every REFRESH_DIV cycles, so the full two-digit frame is 2·REFRESH_DIV cycles.
- **Refresh wrap on the same edge as the E7 update:** the new sel and the new digits take effect together. There is no one-cycle stale mix.

## Test plan
- **Reset:** assert rst_n=0 mid-conversion and mid-scan → immediately busy=0, ovf=0, anode_en=01, digit_out=0. After release, the FSM is in IDLE.
- **Normal conversion:** REFRESH_DIV=4, load value_in=42 → busy high 7 cycles. Then the units slot shows digit_out=2 with anode_en=01, and the tens slot shows digit_out=4 with anode_en=10, alternating every 4 cycles.
- **Leading-zero blanking:** load 7 with LZ_BLANK=1 → tens slot anode_en=00, units slot digit_out=7 with anode_en=01. The same stimulus with LZ_BLANK=0 → tens slot anode_en=10, digit_out=0.
- **Overflow:** load 120 → ovf=1 and display 9/9. A subsequent load of 99 → ovf=0, display 9/9. A load of 0 → units 0 shown, tens blanked.
- **Load while busy:** load 55, then load 13 two cycles later → the second load is ignored, busy drops 7 cycles after the first load, and the display shows 5/5. A load of 13 at E8 is accepted → display 1/3.
- **Exhaustive sweep:** loads 0..127 each produce tens = min(v,99)/10 and units = min(v,99)%10, with ovf = (v>99).

Source files
------------

// File: rtl/display_scan_if.sv
// Bus between the display front-end controller and its host / segment decoder.
// The host loads a value; the controller returns status and the scanned digit.
interface display_scan_if;
  localparam int unsigned VAL_W   = 7;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned AN_W    = 2;

  logic [VAL_W-1:0]   value_in;
  logic               load;
  logic               busy;
  logic               ovf;
  logic [DIGIT_W-1:0] digit_out;
  logic [AN_W-1:0]    anode_en;

  modport master (
    output value_in, load,
    input  busy, ovf, digit_out, anode_en
  );

  modport slave (
    input  value_in, load,
    output busy, ovf, digit_out, anode_en
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Two-digit 7-segment front end: saturating binary-to-BCD conversion with a
// sequential double-dabble engine, then time-multiplexed digit/anode scan.
module display_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter bit          LZ_BLANK    = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  display_scan_if.slave bus
);

  localparam int unsigned VAL_W     = 7;
  localparam int unsigned BCD_W     = 8;
  localparam int unsigned NIB_W     = 4;
  localparam int unsigned STEP_W    = 3;
  localparam int unsigned CNT_W     = $clog2(REFRESH_DIV);
  localparam int unsigned MAX_VAL   = 99;
  localparam int unsigned LAST_STEP = VAL_W - 1;

  typedef enum logic {
    IDLE,
    CONV
  } state_e;

  state_e             state_q, state_d;
  logic [VAL_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [NIB_W-1:0]   tens_q, tens_d;
  logic [NIB_W-1:0]   units_q, units_d;
  logic               busy_q, busy_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sel_q, sel_d;

  logic               over_c;
  logic [VAL_W-1:0]   sat_c;
  logic [NIB_W-2:0]   hi_adj_c;
  logic [NIB_W-1:0]   lo_adj_c;
  logic [BCD_W-1:0]   bcd_shift_c;
  logic [VAL_W-1:0]   bin_shift_c;

  // Saturate before conversion so the BCD result always fits two digits.
  always_comb begin
    over_c = (bus.value_in > VAL_W'(MAX_VAL));
    sat_c  = over_c ? VAL_W'(MAX_VAL) : bus.value_in;
  end

  // One double-dabble step: add-3 per nibble (no cross-nibble carry), then shift.
  // The tens nibble stays below 10, so its adjusted MSB is never shifted out.
  always_comb begin
    hi_adj_c    = (bcd_q[7:4] >= 4'd5) ? 3'(bcd_q[7:4] + 4'd3) : bcd_q[6:4];
    lo_adj_c    = (bcd_q[3:0] >= 4'd5) ? (bcd_q[3:0] + 4'd3) : bcd_q[3:0];
    bcd_shift_c = {hi_adj_c, lo_adj_c, bin_q[VAL_W-1]};
    bin_shift_c = {bin_q[VAL_W-2:0], 1'b0};
  end

  // Conversion FSM: next state and registered outputs.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    step_d  = step_q;
    tens_d  = tens_q;
    units_d = units_q;
    busy_d  = busy_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.load) begin
          bin_d   = sat_c;
          ovf_d   = over_c;
          bcd_d   = '0;
          step_d  = '0;
          busy_d  = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        bin_d  = bin_shift_c;
        bcd_d  = bcd_shift_c;
        step_d = step_q + STEP_W'(1);
        // Digits commit atomically on the final step so the display never tears.
        if (step_q == STEP_W'(LAST_STEP)) begin
          tens_d  = bcd_shift_c[7:4];
          units_d = bcd_shift_c[3:0];
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      step_q  <= '0;
      tens_q  <= '0;
      units_q <= '0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      step_q  <= step_d;
      tens_q  <= tens_d;
      units_q <= units_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  // Free-running scan counter; slot select toggles on each wrap.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    sel_d = sel_q;
    if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
      cnt_d = '0;
      sel_d = ~sel_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sel_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel_d;
    end
  end

  // Output decode from registers only; a zero tens digit may be blanked.
  always_comb begin
    bus.busy      = busy_q;
    bus.ovf       = ovf_q;
    bus.digit_out = sel_q ? tens_q : units_q;
    if (!sel_q) begin
      bus.anode_en = 2'b01;
    end else if (LZ_BLANK && (tens_q == '0)) begin
      bus.anode_en = 2'b00;
    end else begin
      bus.anode_en = 2'b10;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: a driver pushes expected conversions,
// a negedge monitor pops them and checks busy, ovf and the scanned display.
module tb_display_scan_ctrl;

  localparam int unsigned DIV = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  display_scan_if bus1 ();
  display_scan_if bus2 ();

  display_scan_ctrl #(.REFRESH_DIV(DIV), .LZ_BLANK(1'b1)) dut_lz (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  display_scan_ctrl #(.REFRESH_DIV(DIV), .LZ_BLANK(1'b0)) dut_nolz (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int acc;
    int tens;
    int units;
    int ovf;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  int   cyc;
  exp_t q[$];
  int   last_acc  = 0;
  bit   acc_valid = 1'b0;
  int   cur_tens  = 0;
  int   cur_units = 0;
  int   cur_ovf   = 0;

  // Edges since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  function automatic int exp_anode(input int sel, input int tens, input bit lz);
    if (sel == 0) return 1;
    if (lz && tens == 0) return 0;
    return 2;
  endfunction

  // Monitor: conversions are timed from their accept edge; display from cyc.
  always @(negedge clk) begin
    if (rst_n) begin
      int eb, eo, sel;
      eb = 0;
      eo = cur_ovf;
      if (q.size() != 0 && cyc >= q[0].acc) begin
        eo = q[0].ovf;
        if (cyc < q[0].acc + 7) eb = 1;
      end
      if (q.size() != 0 && cyc == q[0].acc + 7) begin
        exp_t e;
        e = q.pop_front();
        cur_tens  = e.tens;
        cur_units = e.units;
        cur_ovf   = e.ovf;
      end
      sel = (cyc / DIV) % 2;
      check("busy_lz",    int'(bus1.busy), eb);
      check("busy_nolz",  int'(bus2.busy), eb);
      check("ovf_lz",     int'(bus1.ovf),  eo);
      check("ovf_nolz",   int'(bus2.ovf),  eo);
      check("digit_lz",   int'(bus1.digit_out), sel ? cur_tens : cur_units);
      check("digit_nolz", int'(bus2.digit_out), sel ? cur_tens : cur_units);
      check("anode_lz",   int'(bus1.anode_en), exp_anode(sel, cur_tens, 1'b1));
      check("anode_nolz", int'(bus2.anode_en), exp_anode(sel, cur_tens, 1'b0));
    end
  end

  task automatic set_in(input int v, input bit l);
    bus1.value_in = 7'(v);
    bus2.value_in = 7'(v);
    bus1.load     = l;
    bus2.load     = l;
  endtask

  // Called just after a negedge: drives one load strobe, then idles `hold` cycles.
  task automatic do_load(input int v, input int hold);
    int edge_n, s;
    edge_n = cyc + 1;
    set_in(v, 1'b1);
    if (!acc_valid || edge_n >= last_acc + 8) begin
      exp_t e;
      s = (v > 99) ? 99 : v;
      e.acc   = edge_n;
      e.tens  = s / 10;
      e.units = s % 10;
      e.ovf   = (v > 99) ? 1 : 0;
      q.push_back(e);
      last_acc  = edge_n;
      acc_valid = 1'b1;
    end
    @(negedge clk);
    set_in(int'($urandom_range(0, 127)), 1'b0);
    repeat (hold) @(negedge clk);
  endtask

  task automatic check_reset_vals();
    check("rst_busy",  int'(bus1.busy), 0);
    check("rst_ovf",   int'(bus1.ovf), 0);
    check("rst_anode", int'(bus1.anode_en), 1);
    check("rst_digit", int'(bus1.digit_out), 0);
    check("rst_anode_nolz", int'(bus2.anode_en), 1);
  endtask

  // Asynchronous reset between edges; model state returns to reset values.
  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_vals();
    q.delete();
    cur_tens  = 0;
    cur_units = 0;
    cur_ovf   = 0;
    acc_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_in(0, 1'b0);
    #3 check_reset_vals();
    #9 rst_n = 1'b1;
    @(negedge clk);

    do_load(42, 14);
    do_load(7, 14);
    do_load(120, 14);
    do_load(99, 14);
    do_load(0, 14);
    // Second load two cycles in is ignored; a load at E8 is accepted.
    do_load(55, 1);
    do_load(13, 0);
    while (cyc + 1 < last_acc + 8) @(negedge clk);
    do_load(13, 14);

    do_load(88, 3);
    do_reset();
    do_load(64, 12);

    for (int v = 0; v < 128; v++) do_load(v, 7 + int'($urandom_range(0, 3)));

    for (int i = 0; i < 200; i++) begin
      do_load(int'($urandom_range(0, 127)), int'($urandom_range(0, 10)));
      if ($urandom_range(0, 49) == 0) do_reset();
    end

    repeat (20) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
